multicycle_adder: RTL

Parametrised, sequential successor to the single-bit full adder: computes `sum = a + b + cin` over `WIDTH` bits by rippling a `SLICE`-bit carry chain across `WIDTH/SLICE` clock cycles. This trades latency for a short critical path. Operands enter through a valid/ready handshake and results leave through one. It also reports carry-out and signed overflow. The block sits in the datapath wherever a wide add is needed and a full-width single-cycle ripple would not close timing.

---
 rtl/adder_pkg.sv | 13 +
 rtl/adder_slice.sv | 23 ++
 rtl/multicycle_adder.sv | 105 ++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared types and parameter checks for the multicycle adder.
package adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} add_state_t;

  // Legal when 1 <= slice <= width and slice divides width evenly.
  function automatic bit params_ok(int width, int slice);
    if (width < 1) return 1'b0;
    if (slice < 1 || slice > width) return 1'b0;
    return (width % slice) == 0;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple-carry adder built from per-bit full adders.
module adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (b[i] & c[i]) | (c[i] & a[i]);
  end

  assign co = c[W];

endmodule

// File: rtl/multicycle_adder.sv
// WIDTH-bit adder that ripples one SLICE-bit chunk per clock; valid/ready on
// both sides, registered sum/cout/ovf held stable while waiting for the consumer.
module multicycle_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = (SLICE > 0) ? WIDTH / SLICE : 1;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (!params_ok(WIDTH, SLICE)) begin : g_bad_params
    $error("multicycle_adder: illegal WIDTH/SLICE combination");
  end

  add_state_t       state, state_nxt;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry;
  logic [SLICE-1:0] sl_a, sl_b, sl_s;
  logic             sl_co;
  logic             last;

  assign sl_a = a_q[idx*SLICE +: SLICE];
  assign sl_b = b_q[idx*SLICE +: SLICE];
  assign last = (idx == IDXW'(NSLICE - 1));

  adder_slice #(.W(SLICE)) u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .ci (carry),
    .s  (sl_s),
    .co (sl_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN:  if (last) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q   <= a;
          b_q   <= b;
          carry <= cin;
          idx   <= '0;
        end
        RUN: begin
          sum[idx*SLICE +: SLICE] <= sl_s;
          carry <= sl_co;
          idx   <= idx + 1'b1;
          // Last slice's top bit is the final sum MSB.
          if (last) begin
            cout <= sl_co;
            ovf  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sl_s[SLICE-1] != a_q[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
